// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Constants and types shared across the audio note pipeline
//                (note_lookup, note_stabilizer, duration_detector,
//                image_sprite).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Width of a note index and the index that means silence.
    localparam int               NOTE_W    = 6;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    // Vote sequencer states for note_stabilizer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2
    } stab_state_t;

endpackage
`default_nettype wire

// File: rtl/note_stabilizer.sv
`default_nettype none
// ============================================================================
//  Module      : note_stabilizer
//  Description : Sliding-window majority filter on the per-frame note index.
//                Each accepted sample is shifted into a WINDOW-deep history,
//                its matches are counted one entry per cycle, and it becomes
//                the stable note once it holds at least MIN_VOTES entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_stabilizer #(
    parameter int                WINDOW    = 8,
    parameter int                MIN_VOTES = 5,
    parameter int                NOTE_W    = audio_pkg::NOTE_W,
    parameter logic [NOTE_W-1:0] REST_NOTE = audio_pkg::REST_NOTE
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NOTE_W-1:0]            note_index_in,
    input  logic                         note_valid_in,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         note_valid_out,
    output logic                         note_changed_out,
    output logic [$clog2(WINDOW+1)-1:0]  confidence_out,
    output logic                         overrun_out
);

    import audio_pkg::*;

    localparam int                 c_IDX_W     = $clog2(WINDOW);
    localparam int                 c_CNT_W     = $clog2(WINDOW + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(WINDOW - 1);
    localparam logic [c_CNT_W-1:0] c_MIN_VOTES = c_CNT_W'(MIN_VOTES);

    stab_state_t        r_state;
    stab_state_t        w_state_next;

    logic [NOTE_W-1:0]  r_hist [WINDOW];
    logic [NOTE_W-1:0]  r_cand;
    logic [NOTE_W-1:0]  r_pend;
    logic               r_pend_full;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_CNT_W-1:0] r_count;

    logic               w_accept;
    logic               w_count_en;
    logic               w_decide;
    logic [NOTE_W-1:0]  w_accept_note;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state: accept -> scan WINDOW entries -> one decision cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (note_valid_in || r_pend_full) w_state_next = COUNT;
            COUNT:   if (r_idx == c_LAST_IDX)          w_state_next = DECIDE;
            DECIDE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM decodes; a waiting pending sample is served before a fresh strobe.
    always_comb begin
        w_accept      = (r_state == IDLE) && (note_valid_in || r_pend_full);
        w_count_en    = (r_state == COUNT);
        w_decide      = (r_state == DECIDE);
        w_accept_note = r_pend_full ? r_pend : note_index_in;
    end

    // History shift register, newest sample at entry 0.
    for (genvar i = 0; i < WINDOW; i++) begin : g_hist
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                r_hist[i] <= REST_NOTE;
            end else if (w_accept) begin
                if (i == 0) r_hist[i] <= w_accept_note;
                else        r_hist[i] <= r_hist[(i == 0) ? 0 : i - 1];
            end
        end
    end

    // Single-entry pending buffer for strobes that arrive while a vote runs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pend      <= REST_NOTE;
            r_pend_full <= 1'b0;
            overrun_out <= 1'b0;
        end else if (w_accept) begin
            // Pending is consumed; a coincident strobe takes its place.
            r_pend_full <= r_pend_full && note_valid_in;
            if (r_pend_full && note_valid_in) r_pend <= note_index_in;
        end else if (note_valid_in) begin
            r_pend      <= note_index_in;
            r_pend_full <= 1'b1;
            if (r_pend_full) overrun_out <= 1'b1;
        end
    end

    // Match counter: one history entry compared per COUNT cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cand  <= REST_NOTE;
            r_idx   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_cand  <= w_accept_note;
            r_idx   <= '0;
            r_count <= '0;
        end else if (w_count_en) begin
            if (r_hist[r_idx] == r_cand) r_count <= r_count + c_CNT_W'(1);
            r_idx <= r_idx + c_IDX_W'(1);
        end
    end

    // Decision outputs: registered once per vote, pulses last one cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            note_out         <= REST_NOTE;
            note_valid_out   <= 1'b0;
            note_changed_out <= 1'b0;
            confidence_out   <= '0;
        end else begin
            note_valid_out   <= w_decide;
            note_changed_out <= w_decide && (r_count >= c_MIN_VOTES) && (r_cand != note_out);
            if (w_decide) begin
                confidence_out <= r_count;
                if ((r_count >= c_MIN_VOTES) && (r_cand != note_out)) note_out <= r_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_stabilizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_stabilizer
//  Description : Self-checking bench for note_stabilizer (WINDOW=8,
//                MIN_VOTES=5, REST_NOTE=0) against a queue-based majority
//                vote reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_stabilizer;

    localparam int c_WINDOW = 8;
    localparam int c_VOTES  = 5;
    localparam int c_LAT    = c_WINDOW + 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [5:0] note_index_in = '0;
    logic       note_valid_in = 1'b0;
    logic [5:0] note_out;
    logic       note_valid_out;
    logic       note_changed_out;
    logic [3:0] confidence_out;
    logic       overrun_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: most recent WINDOW samples and the stable note.
    logic [5:0] m_hist[$];
    logic [5:0] m_note;

    note_stabilizer #(
        .WINDOW    (c_WINDOW),
        .MIN_VOTES (c_VOTES),
        .NOTE_W    (6),
        .REST_NOTE (6'd0)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .note_index_in    (note_index_in),
        .note_valid_in    (note_valid_in),
        .note_out         (note_out),
        .note_valid_out   (note_valid_out),
        .note_changed_out (note_changed_out),
        .confidence_out   (confidence_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < c_WINDOW; i++) m_hist.push_back(6'd0);
        m_note = 6'd0;
    endtask

    // Majority vote over the window after adding sample n.
    task automatic model_vote(input logic [5:0] n, output int conf, output bit chg);
        m_hist.push_front(n);
        void'(m_hist.pop_back());
        conf = 0;
        foreach (m_hist[i]) if (m_hist[i] == n) conf++;
        chg = (conf >= c_VOTES) && (n != m_note);
        if (chg) m_note = n;
    endtask

    // Waits (bounded) for note_valid_out, sampling on falling edges.
    task automatic wait_valid(input int lat0, output int lat, output bit seen);
        lat  = lat0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (note_valid_out) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
            lat++;
        end
    endtask

    // One-cycle strobe, then wait for its decision.
    task automatic send_note(input logic [5:0] n, output int lat, output bit seen);
        @(negedge clk_in);
        note_index_in = n;
        note_valid_in = 1'b1;
        @(negedge clk_in);
        note_valid_in = 1'b0;
        wait_valid(1, lat, seen);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        @(negedge clk_in);
        n_checks++; if (note_out !== 6'd0) $display("FAIL reset_note got %0d want 0", note_out); else n_pass++;
        n_checks++; if (confidence_out !== 4'd0) $display("FAIL reset_conf got %0d want 0", confidence_out); else n_pass++;
        n_checks++; if (note_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", note_valid_out); else n_pass++;
        n_checks++; if (note_changed_out !== 1'b0) $display("FAIL reset_changed got %b want 0", note_changed_out); else n_pass++;
        n_checks++; if (overrun_out !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun_out); else n_pass++;
    endtask

    task automatic test_onset();
        int lat; bit seen; int e_conf; bit e_chg;
        for (int k = 0; k < 5; k++) begin
            model_vote(6'd20, e_conf, e_chg);
            send_note(6'd20, lat, seen);
            n_checks++; if (!seen || lat != c_LAT) $display("FAIL onset_latency[%0d] got %0d (seen=%b) want %0d", k, lat, seen, c_LAT); else n_pass++;
            n_checks++; if (note_out !== m_note) $display("FAIL onset_note[%0d] got %0d want %0d", k, note_out, m_note); else n_pass++;
            n_checks++; if (confidence_out !== 4'(e_conf)) $display("FAIL onset_conf[%0d] got %0d want %0d", k, confidence_out, e_conf); else n_pass++;
            n_checks++; if (note_changed_out !== e_chg) $display("FAIL onset_changed[%0d] got %b want %b", k, note_changed_out, e_chg); else n_pass++;
            @(negedge clk_in);
            n_checks++; if ({note_valid_out, note_changed_out} !== 2'b00) $display("FAIL onset_pulse[%0d] got %b%b want 00", k, note_valid_out, note_changed_out); else n_pass++;
            repeat (38) @(negedge clk_in);
        end
        n_checks++; if (note_out !== 6'd20) $display("FAIL onset_final got %0d want 20", note_out); else n_pass++;
    endtask

    task automatic test_glitch();
        int lat; bit seen; int e_conf; bit e_chg;
        logic [5:0] seq [5];
        seq = '{6'd20, 6'd20, 6'd20, 6'd33, 6'd20};
        for (int k = 0; k < 5; k++) begin
            model_vote(seq[k], e_conf, e_chg);
            send_note(seq[k], lat, seen);
            n_checks++; if (!seen) $display("FAIL glitch_seen[%0d] got 0 want 1", k); else n_pass++;
            n_checks++; if (note_out !== m_note || confidence_out !== 4'(e_conf) || note_changed_out !== e_chg)
                $display("FAIL glitch[%0d] got note=%0d conf=%0d chg=%b want note=%0d conf=%0d chg=%b",
                         k, note_out, confidence_out, note_changed_out, m_note, e_conf, e_chg);
            else n_pass++;
            @(negedge clk_in);
        end
        n_checks++; if (confidence_out !== 4'd7 || note_out !== 6'd20) $display("FAIL glitch_final got note=%0d conf=%0d want note=20 conf=7", note_out, confidence_out); else n_pass++;
    endtask

    task automatic test_random();
        int lat; bit seen; int e_conf; bit e_chg;
        logic [5:0] pool [4];
        logic [5:0] n;
        pool = '{6'd0, 6'd5, 6'd6, 6'd7};
        for (int k = 0; k < 30; k++) begin
            n = pool[$urandom_range(0, 3)];
            model_vote(n, e_conf, e_chg);
            send_note(n, lat, seen);
            n_checks++; if (!seen || lat != c_LAT || note_out !== m_note || confidence_out !== 4'(e_conf) || note_changed_out !== e_chg)
                $display("FAIL random[%0d] n=%0d got lat=%0d note=%0d conf=%0d chg=%b want lat=%0d note=%0d conf=%0d chg=%b",
                         k, n, lat, note_out, confidence_out, note_changed_out, c_LAT, m_note, e_conf, e_chg);
            else n_pass++;
            @(negedge clk_in);
            n_checks++; if (note_valid_out !== 1'b0) $display("FAIL random_pulse[%0d] got 1 want 0", k); else n_pass++;
            repeat ($urandom_range(0, 6)) @(negedge clk_in);
        end
    endtask

    task automatic test_min_votes();
        int lat; bit seen; int e_conf; bit e_chg;
        test_reset();
        for (int k = 0; k < 4; k++) begin
            model_vote(6'd20, e_conf, e_chg);
            send_note(6'd20, lat, seen);
            @(negedge clk_in);
        end
        for (int k = 0; k < 5; k++) begin
            model_vote(6'd41, e_conf, e_chg);
            send_note(6'd41, lat, seen);
            n_checks++; if (!seen || confidence_out !== 4'(k + 1)) $display("FAIL minvotes_conf[%0d] got %0d want %0d", k, confidence_out, k + 1); else n_pass++;
            n_checks++; if (note_changed_out !== (k == 4) || note_changed_out !== e_chg) $display("FAIL minvotes_changed[%0d] got %b want %b", k, note_changed_out, (k == 4)); else n_pass++;
            n_checks++; if (note_out !== ((k == 4) ? 6'd41 : 6'd0)) $display("FAIL minvotes_note[%0d] got %0d want %0d", k, note_out, (k == 4) ? 41 : 0); else n_pass++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_overrun();
        int lat; bit seen; int e_conf; bit e_chg; bit extra;
        @(negedge clk_in); note_index_in = 6'd3; note_valid_in = 1'b1;
        @(negedge clk_in); note_valid_in = 1'b0;
        @(negedge clk_in); note_index_in = 6'd7; note_valid_in = 1'b1;
        @(negedge clk_in); note_valid_in = 1'b0;
        @(negedge clk_in); note_index_in = 6'd9; note_valid_in = 1'b1;
        @(negedge clk_in); note_valid_in = 1'b0;
        model_vote(6'd3, e_conf, e_chg);
        wait_valid(5, lat, seen);
        n_checks++; if (!seen || lat != c_LAT || confidence_out !== 4'(e_conf)) $display("FAIL overrun_first got lat=%0d conf=%0d want lat=%0d conf=%0d", lat, confidence_out, c_LAT, e_conf); else n_pass++;
        model_vote(6'd9, e_conf, e_chg);
        @(negedge clk_in);
        wait_valid(0, lat, seen);
        n_checks++; if (!seen || confidence_out !== 4'(e_conf) || note_out !== m_note) $display("FAIL overrun_second got seen=%b conf=%0d note=%0d want conf=%0d note=%0d", seen, confidence_out, note_out, e_conf, m_note); else n_pass++;
        n_checks++; if (overrun_out !== 1'b1) $display("FAIL overrun_flag got %b want 1", overrun_out); else n_pass++;
        extra = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            if (note_valid_out) extra = 1'b1;
        end
        n_checks++; if (extra !== 1'b0) $display("FAIL overrun_extra_vote got 1 want 0"); else n_pass++;
        n_checks++; if (overrun_out !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun_out); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat; bit seen; int e_conf; bit e_chg; bit stray;
        @(negedge clk_in); note_index_in = 6'd9; note_valid_in = 1'b1;
        @(negedge clk_in); note_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (note_out !== 6'd0 || confidence_out !== 4'd0 || overrun_out !== 1'b0 || note_valid_out !== 1'b0 || note_changed_out !== 1'b0)
            $display("FAIL async_reset got note=%0d conf=%0d ovr=%b vld=%b chg=%b want all 0", note_out, confidence_out, overrun_out, note_valid_out, note_changed_out);
        else n_pass++;
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (note_valid_out) stray = 1'b1;
        end
        rst_in = 1'b1;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            if (note_valid_out) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) $display("FAIL async_no_vote got 1 want 0"); else n_pass++;
        model_vote(6'd12, e_conf, e_chg);
        send_note(6'd12, lat, seen);
        n_checks++; if (!seen || lat != c_LAT || confidence_out !== 4'd1 || note_out !== 6'd0 || note_changed_out !== 1'b0)
            $display("FAIL async_after got lat=%0d conf=%0d note=%0d chg=%b want lat=%0d conf=1 note=0 chg=0", lat, confidence_out, note_out, note_changed_out, c_LAT);
        else n_pass++;
        n_checks++; if (confidence_out !== 4'(e_conf) || note_out !== m_note) $display("FAIL async_model got conf=%0d note=%0d want conf=%0d note=%0d", confidence_out, note_out, e_conf, m_note); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_onset();
        test_glitch();
        test_random();
        test_min_votes();
        test_overrun();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_stabilizer.md
Name: note_stabilizer

Overview:
- Sliding-window majority filter between note_lookup and duration_detector.
- Rejects single-frame pitch glitches, such as FFT peak jitter or octave errors, before the duration logic sees them.
- Consumes one note index per FFT frame.
- Emits a registered stable note, a match-count confidence and a one-cycle change pulse.
- Runs in the clk_m audio/FFT domain.

Parameters:
- WINDOW, 8, number of most recent note samples held in the history; power of 2, range 4..16.
- MIN_VOTES, 5, matches of the newest sample required to adopt it as the stable note; must satisfy 1 <= MIN_VOTES <= WINDOW.
- NOTE_W, 6, width of a note index.
- REST_NOTE, 0, index meaning silence; reset fill value of the history and of note_out.

Ports:
- clk_in  input  1  system clock (clk_m).
- rst_in  input  1  asynchronous, active-low reset.
- note_index_in  input  NOTE_W  note index from note_lookup.
- note_valid_in  input  1  single-cycle strobe qualifying note_index_in.
- note_out  output  NOTE_W  current stable note.
- note_valid_out  output  1  one-cycle pulse per completed vote.
- note_changed_out  output  1  one-cycle pulse, coincident with note_valid_out, when note_out changed.
- confidence_out  output  $clog2(WINDOW+1)  match count from the last vote.
- overrun_out  output  1  sticky flag: a pending sample was overwritten.

Behaviour:
- Reset values (rst_in low; asynchronous assert, synchronous deassert):
  - all history entries = REST_NOTE, note_out = REST_NOTE;
  - note_valid_out = 0, note_changed_out = 0, confidence_out = 0, overrun_out = 0;
  - pending empty, FSM in IDLE.
- History: WINDOW-entry shift register, newest at index 0. Accepting a sample shifts every entry by one; the oldest entry is discarded.
- FSM states: IDLE, COUNT, DECIDE.
  - IDLE:
    - if note_valid_in is high, or pending is full, accept the sample, with pending taking priority, and clear pending;
    - on acceptance, shift it into the history, latch it as candidate, clear the counter and idx, and go to COUNT.
  - COUNT:
    - one history entry per cycle, idx = 0..WINDOW-1;
    - counter increments when entry[idx] == candidate;
    - after idx == WINDOW-1, go to DECIDE.
  - DECIDE (one cycle):
    - confidence_out <= final count; note_valid_out <= 1;
    - if count >= MIN_VOTES and candidate != note_out: note_out <= candidate and note_changed_out <= 1;
    - go to IDLE.
- Latency: note_valid_out asserts exactly WINDOW+2 cycles after the cycle in which note_valid_in was sampled high from IDLE.
- Pulse discipline: note_valid_out and note_changed_out are high for exactly one cycle and low at all other times.
- note_valid_in while in COUNT or DECIDE: the sample is stored in a single-entry pending register.
  - If pending is already full, overwrite it with the newer sample and set overrun_out; it stays set until reset.
  - A strobe arriving in DECIDE is captured normally.
- Simultaneous pending full and note_valid_in in IDLE: pending is consumed; the new strobe goes to pending. This cannot normally occur, but this is the required behaviour.
- Comparison is exact equality on NOTE_W bits. REST_NOTE is voted like any other note, so sustained silence returns note_out to REST_NOTE.
- Counter saturates at WINDOW by construction; no overflow is possible.
- Reset mid-COUNT: outputs and history return to reset values immediately; any partial vote is discarded.

Decomposition:
- Shared package audio_pkg holds:
  - the NOTE_W constant and REST_NOTE constant, shared with note_lookup, duration_detector and image_sprite;
  - the stab_state_t enum {IDLE, COUNT, DECIDE}.
- No sub-module is required. An optional inline match_counter is not separated out; the FSM, history and pending register are all contained in note_stabilizer.

Test Plan (WINDOW=8, MIN_VOTES=5, REST_NOTE=0):
- Reset: hold rst_in low, then release -> note_out=0, confidence_out=0, all pulses 0, overrun_out=0.
- Note onset: 5 strobes of note 20, spaced 50 cycles -> decisions 1-4 give note_out=0 with confidence 1,2,3,4; decision 5 gives note_out=20, note_changed_out=1, confidence_out=5, each note_valid_out exactly 10 cycles after its strobe.
- Glitch rejection: starting stable at 20 with a full window of 20s, inject one 33, then 20 -> note_out stays 20, no change pulse; confidence_out is 1 for the glitch, then 7.
- MIN_VOTES boundary: window of four 20s and four 0s plus a new 41 -> no change. Then feed 41 until its count reaches 5 -> change occurs on exactly the fifth matching decision.
- Overrun: strobe, then two more strobes (notes 7 and 9) during COUNT -> only 9 is voted next, overrun_out=1 and held.
- Async reset mid-COUNT: drop rst_in 3 cycles into COUNT -> outputs clear in the same cycle, with no note_valid_out. After release, one strobe of 12 gives confidence_out=1 and note_out=0.
